// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel-rate prescaler, H/V counters, and a latency-matched
// output stage that aligns sync/blank with the colour-mapped pixel bit.
module vga_timing_generator #(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = 800,
    parameter int H_FP    = 40,
    parameter int H_SYNC  = 128,
    parameter int H_TOTAL = 1056,
    parameter int V_VIS   = 600,
    parameter int V_FP    = 1,
    parameter int V_SYNC  = 4,
    parameter int V_TOTAL = 628,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1,
    parameter int PIX_LAT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pixel_bit,
    input  logic [23:0] fg_color,
    input  logic [23:0] bg_color,
    output logic [10:0] H_counter,
    output logic [9:0]  V_counter,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_bad_div
        $error("CLK_DIV must be in 1..8");
    end
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
        $error("PIX_LAT must be in 1..4");
    end
    if (H_VIS + H_FP + H_SYNC > H_TOTAL) begin : g_bad_h
        $error("horizontal timing exceeds H_TOTAL");
    end
    if (V_VIS + V_FP + V_SYNC > V_TOTAL) begin : g_bad_v
        $error("vertical timing exceeds V_TOTAL");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_C = 11'(H_VIS);
    localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_C = 10'(V_VIS);
    localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    logic [DW-1:0] div_cnt;
    logic          tick_now;
    logic          h_wrap;
    logic          v_wrap;
    logic          vis;
    logic          hs_act;
    logic          vs_act;
    logic [2:0]    pipe [PIX_LAT];
    logic [2:0]    tail;
    logic [23:0]   rgb;

    always_comb begin
        tick_now = (div_cnt == DIV_LAST);
        h_wrap   = (H_counter == H_LAST);
        v_wrap   = (V_counter == V_LAST);
        vis      = (H_counter < H_VIS_C) && (V_counter < V_VIS_C);
        hs_act   = (H_counter >= HS_BEG) && (H_counter < HS_END);
        vs_act   = (V_counter >= VS_BEG) && (V_counter < VS_END);
    end

    // Pipeline entries are {vis, hs_act, vs_act}; the tail lines up with pixel_bit.
    assign tail = pipe[PIX_LAT-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt     <= '0;
            pix_tick    <= 1'b0;
            frame_start <= 1'b0;
            H_counter   <= '0;
            V_counter   <= '0;
            for (int i = 0; i < PIX_LAT; i++) pipe[i] <= 3'b000;
            blank_n     <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            rgb         <= '0;
        end else begin
            pix_tick    <= tick_now;
            frame_start <= tick_now && h_wrap && v_wrap;
            div_cnt     <= tick_now ? '0 : div_cnt + DW'(1);
            if (tick_now) begin
                if (h_wrap) begin
                    H_counter <= '0;
                    V_counter <= v_wrap ? '0 : V_counter + 10'd1;
                end else begin
                    H_counter <= H_counter + 11'd1;
                end
                pipe[0] <= {vis, hs_act, vs_act};
                for (int i = 1; i < PIX_LAT; i++) pipe[i] <= pipe[i-1];
                blank_n <= tail[2];
                hsync   <= tail[1] ? HS_ON : ~HS_ON;
                vsync   <= tail[0] ? VS_ON : ~VS_ON;
                rgb     <= tail[2] ? (pixel_bit ? fg_color : bg_color) : 24'h0;
            end
        end
    end

    assign VGA_R = rgb[23:16];
    assign VGA_G = rgb[15:8];
    assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: four parameter sets side by side, checked every
// cycle against an arithmetic raster model plus hand-computed timing landmarks.
module tb_vga_timing_generator;

    localparam int NI = 4;
    // cfg0 = default 800x600 timing; cfg1..3 = shrunk rasters so whole frames fit the run
    localparam int CD  [NI] = '{2, 2, 1, 3};
    localparam int HV  [NI] = '{800, 16, 16, 16};
    localparam int HF  [NI] = '{40, 2, 2, 2};
    localparam int HS  [NI] = '{128, 4, 4, 4};
    localparam int HT  [NI] = '{1056, 24, 24, 24};
    localparam int VV  [NI] = '{600, 6, 6, 6};
    localparam int VF  [NI] = '{1, 1, 1, 1};
    localparam int VS  [NI] = '{4, 2, 2, 2};
    localparam int VT  [NI] = '{628, 10, 10, 10};
    localparam int HP  [NI] = '{1, 1, 0, 1};
    localparam int VP  [NI] = '{1, 1, 0, 0};
    localparam int LAT [NI] = '{1, 1, 3, 2};

    // hand-computed landmarks: sync width, counter H at aligned sync start, etc.
    localparam int HSW_X [NI] = '{128, 4, 4, 4};
    localparam int HSR_X [NI] = '{842, 20, 22, 21};
    localparam int BLW_X [NI] = '{800, 16, 16, 16};
    localparam int VSW_X [NI] = '{0, 48, 48, 48};
    localparam int VSR_X [NI] = '{0, 7, 7, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [NI];
    logic        pix [NI];
    logic [23:0] fg, bg;

    logic [10:0] o_h [NI];
    logic [9:0]  o_v [NI];
    logic        o_tick [NI], o_fs [NI], o_hs [NI], o_vs [NI], o_bl [NI];
    logic [7:0]  o_r [NI], o_g [NI], o_b [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_generator #(
            .CLK_DIV(CD[g]), .H_VIS(HV[g]), .H_FP(HF[g]), .H_SYNC(HS[g]), .H_TOTAL(HT[g]),
            .V_VIS(VV[g]), .V_FP(VF[g]), .V_SYNC(VS[g]), .V_TOTAL(VT[g]),
            .HS_POL(HP[g]), .VS_POL(VP[g]), .PIX_LAT(LAT[g])
        ) u_dut (
            .CLK(clk), .RST(rst[g]), .pixel_bit(pix[g]),
            .fg_color(fg), .bg_color(bg),
            .H_counter(o_h[g]), .V_counter(o_v[g]),
            .pix_tick(o_tick[g]), .frame_start(o_fs[g]),
            .hsync(o_hs[g]), .vsync(o_vs[g]), .blank_n(o_bl[g]),
            .VGA_R(o_r[g]), .VGA_G(o_g[g]), .VGA_B(o_b[g])
        );
    end

    // model state: clocks and pixel ticks since reset release
    int          m_c [NI], m_t [NI];
    logic [10:0] e_h [NI];
    logic [9:0]  e_v [NI];
    logic        e_tick [NI], e_fs [NI], e_hs [NI], e_vs [NI], e_bl [NI];
    logic [23:0] e_rgb [NI];

    int   hs_run [NI], hs_w [NI], hs_rise_h [NI];
    int   vs_run [NI], vs_w [NI], vs_rise_v [NI];
    int   bl_run [NI], bl_w [NI], fs_cnt [NI];
    logic hs_prev [NI], vs_prev [NI];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected outputs from raster arithmetic: the outputs describe the position
    // that was on the counters LAT+1 ticks ago; colour follows H parity.
    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            if (rst[g]) begin
                m_c[g] = 0; m_t[g] = 0;
                e_h[g] = '0; e_v[g] = '0; e_tick[g] = 1'b0; e_fs[g] = 1'b0;
                e_hs[g] = 1'(1 - HP[g]); e_vs[g] = 1'(1 - VP[g]);
                e_bl[g] = 1'b0; e_rgb[g] = '0;
            end else begin
                m_c[g]++;
                e_tick[g] = (m_c[g] % CD[g]) == 0;
                e_fs[g] = 1'b0;
                if (e_tick[g]) begin
                    int p, ph, pv;
                    logic vis, hin, vin;
                    m_t[g]++;
                    e_h[g]  = 11'(m_t[g] % HT[g]);
                    e_v[g]  = 10'((m_t[g] / HT[g]) % VT[g]);
                    e_fs[g] = (m_t[g] % (HT[g] * VT[g])) == 0;
                    if (m_t[g] > LAT[g]) begin
                        p   = m_t[g] - LAT[g] - 1;
                        ph  = p % HT[g];
                        pv  = (p / HT[g]) % VT[g];
                        vis = (ph < HV[g]) && (pv < VV[g]);
                        hin = (ph >= HV[g] + HF[g]) && (ph < HV[g] + HF[g] + HS[g]);
                        vin = (pv >= VV[g] + VF[g]) && (pv < VV[g] + VF[g] + VS[g]);
                        e_bl[g]  = vis;
                        e_hs[g]  = hin ? 1'(HP[g]) : 1'(1 - HP[g]);
                        e_vs[g]  = vin ? 1'(VP[g]) : 1'(1 - VP[g]);
                        e_rgb[g] = vis ? (((ph % 2) == 1) ? fg : bg) : 24'h0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < NI; g++) begin
            logic [23:0] rgb;
            logic ha, va;
            rgb = {o_r[g], o_g[g], o_b[g]};
            vectors++;
            if (o_h[g] !== e_h[g] || o_v[g] !== e_v[g] || o_tick[g] !== e_tick[g] ||
                o_fs[g] !== e_fs[g] || o_hs[g] !== e_hs[g] || o_vs[g] !== e_vs[g] ||
                o_bl[g] !== e_bl[g] || rgb !== e_rgb[g]) begin
                miscompares++;
                $display("FAIL cycle cfg%0d clk=%0d: got h=%0d v=%0d tick=%b fs=%b hs=%b vs=%b bl=%b rgb=%h, want h=%0d v=%0d tick=%b fs=%b hs=%b vs=%b bl=%b rgb=%h",
                         g, m_c[g], o_h[g], o_v[g], o_tick[g], o_fs[g], o_hs[g], o_vs[g], o_bl[g], rgb,
                         e_h[g], e_v[g], e_tick[g], e_fs[g], e_hs[g], e_vs[g], e_bl[g], e_rgb[g]);
            end
            if (o_fs[g] === 1'b1) fs_cnt[g]++;
            if (o_tick[g] === 1'b1) begin
                ha = (o_hs[g] == 1'(HP[g]));
                va = (o_vs[g] == 1'(VP[g]));
                if (ha && !hs_prev[g]) hs_rise_h[g] = int'(o_h[g]);
                if (va && !vs_prev[g]) vs_rise_v[g] = int'(o_v[g]);
                if (ha) hs_run[g]++;
                else if (hs_run[g] > 0) begin hs_w[g] = hs_run[g]; hs_run[g] = 0; end
                if (va) vs_run[g]++;
                else if (vs_run[g] > 0) begin vs_w[g] = vs_run[g]; vs_run[g] = 0; end
                if (o_bl[g]) bl_run[g]++;
                else if (bl_run[g] > 0) begin bl_w[g] = bl_run[g]; bl_run[g] = 0; end
                hs_prev[g] = ha;
                vs_prev[g] = va;
            end
        end
    endtask

    // Downstream controller stand-in: returns H[0] of the position issued LAT ticks ago.
    task automatic drive_pix();
        for (int g = 0; g < NI; g++)
            pix[g] = (m_t[g] >= LAT[g]) ? (((m_t[g] - LAT[g]) % HT[g]) % 2 == 1) : 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        drive_pix();
    endtask

    initial begin
        int n;
        fg = 24'hFF0000;
        bg = 24'h0000FF;
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b1; pix[g] = 1'b0; hs_prev[g] = 1'b0; vs_prev[g] = 1'b0;
        end
        repeat (3) cycle();
        check("reset_hsync_idle_pol0", int'(o_hs[2]), 1);
        check("reset_vsync_idle_pol0", int'(o_vs[2]), 1);
        check("reset_hsync_idle_pol1", int'(o_hs[0]), 0);
        check("reset_blank_n", int'(o_bl[0]), 0);

        for (int g = 0; g < NI; g++) rst[g] = 1'b0;
        cycle();
        check("div1_tick_clk1", int'(o_tick[2]), 1);
        check("div1_h_clk1", int'(o_h[2]), 1);
        check("div2_tick_clk1", int'(o_tick[0]), 0);
        check("div2_h_clk1", int'(o_h[0]), 0);
        cycle();
        check("div2_tick_clk2", int'(o_tick[0]), 1);
        check("div2_h_clk2", int'(o_h[0]), 1);
        check("model_h_clk2", int'(e_h[0]), 1);
        check("div1_h_clk2", int'(o_h[2]), 2);
        cycle();
        check("div3_tick_clk3", int'(o_tick[3]), 1);
        check("div2_tick_clk3", int'(o_tick[0]), 0);

        repeat (997) cycle();
        check("frame_pulses_cfg0", fs_cnt[0], 0);
        check("frame_pulses_cfg1", fs_cnt[1], 2);
        check("frame_pulses_cfg2", fs_cnt[2], 4);
        check("frame_pulses_cfg3", fs_cnt[3], 1);

        fg = 24'h00FF00;
        bg = 24'h202020;

        n = 0;
        while (!(e_h[1] == 11'd10 && e_v[1] == 10'd3) && n < 1000) begin
            cycle();
            n++;
        end
        check("reset_point_reached", int'(n < 1000), 1);
        rst[1] = 1'b1;
        #1;
        check("midreset_h", int'(o_h[1]), 0);
        check("midreset_v", int'(o_v[1]), 0);
        check("midreset_blank_n", int'(o_bl[1]), 0);
        check("midreset_rgb", int'({o_r[1], o_g[1], o_b[1]}), 0);
        check("midreset_hsync", int'(o_hs[1]), 0);
        check("midreset_tick", int'(o_tick[1]), 0);
        cycle();
        rst[1] = 1'b0;
        n = 0;
        do begin
            cycle();
            n++;
        end while (o_fs[1] !== 1'b1 && n < 2000);
        check("restart_clks_to_frame_start", n, 480);

        repeat (5000) cycle();
        for (int g = 0; g < NI; g++) begin
            check($sformatf("hsync_width_cfg%0d", g), hs_w[g], HSW_X[g]);
            check($sformatf("hsync_start_h_cfg%0d", g), hs_rise_h[g], HSR_X[g]);
            check($sformatf("blank_width_cfg%0d", g), bl_w[g], BLW_X[g]);
            if (g > 0) begin
                check($sformatf("vsync_width_cfg%0d", g), vs_w[g], VSW_X[g]);
                check($sformatf("vsync_start_v_cfg%0d", g), vs_rise_v[g], VSR_X[g]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
